imm_prefix_stage: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts instructions over a valid/ready handshake and decodes the 5-, 6- or 8-bit sign-extended immediate, with an optional left shift by 1. It also supports chained immediate-prefix instructions, which extend the next instruction's immediate beyond 8 bits. It produces one registered immediate plus the passed-through instruction per non-prefix instruction, and sits between fetch and the register-read stage.

---
 rtl/imm_pkg.sv | 45 ++++
 rtl/imm_prefix_stage_extract.sv | 54 +++++
 rtl/imm_prefix_stage.sv | 117 +++++++++++
 tb/tb_imm_prefix_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants, formats and decode helpers for the immediate generator.
// Opcode masks select the 6-bit, 8-bit and shift forms; prefix payloads are 12 bits.
package imm_pkg;

   localparam int PREFIX_PAYLOAD_W = 12;

   localparam logic [3:0] DEF_PREFIX_OPCODE = 4'hF;

   // 6-bit form: op == 0X0X
   localparam logic [3:0] OP6_MASK  = 4'b1010;
   localparam logic [3:0] OP6_MATCH = 4'b0000;
   // 8-bit form: op == X010
   localparam logic [3:0] OP8_MASK  = 4'b0111;
   localparam logic [3:0] OP8_MATCH = 4'b0010;
   // shift-by-1: op[3] == 0
   localparam logic [3:0] SHL_MASK  = 4'b1000;
   localparam logic [3:0] SHL_MATCH = 4'b0000;

   typedef enum logic [1:0] {
      IMM5,
      IMM6,
      IMM8
   } immFmt_e;

   typedef enum logic {
      IDLE,
      PREFIXED
   } pfxState_e;

   function automatic immFmt_e decodeFmt(input logic [3:0] op);
      immFmt_e fmt;
      fmt = IMM5;
      unique case (1'b1)
         ((op & OP6_MASK) == OP6_MATCH): fmt = IMM6;
         ((op & OP8_MASK) == OP8_MATCH): fmt = IMM8;
         default:                        fmt = IMM5;
      endcase
      return fmt;
   endfunction

   function automatic logic isShift(input logic [3:0] op);
      return (op & SHL_MASK) == SHL_MATCH;
   endfunction

endpackage

// File: rtl/imm_prefix_stage_extract.sv
// imm_extract: combinational immediate builder from opcode, source byte, prefix acc/cnt.
// Ports: op, immSrc in; acc, cnt in; imm out (DATA_WIDTH, unregistered).
module imm_extract
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_PREFIX = 2,
   parameter int CNT_W      = 2
) (
   input  logic [3:0]                             op,
   input  logic [7:0]                             immSrc,
   input  logic [MAX_PREFIX*PREFIX_PAYLOAD_W-1:0] acc,
   input  logic [CNT_W-1:0]                       cnt,
   output logic [DATA_WIDTH-1:0]                  imm
);

   localparam int ACC_W = MAX_PREFIX * PREFIX_PAYLOAD_W;
   // Wide enough for the full chain plus field and any sign fill.
   localparam int EXT_W = ACC_W + 8 + DATA_WIDTH;

   immFmt_e          fmt;
   int               fw;
   int               w;
   logic [EXT_W-1:0] field;
   logic [EXT_W-1:0] combined;
   logic [EXT_W-1:0] lowMask;
   logic [EXT_W-1:0] topMask;
   logic [EXT_W-1:0] ext;
   logic [DATA_WIDTH-1:0] base;

   always_comb begin
      fmt = decodeFmt(op);
      fw  = 5;
      unique case (fmt)
         IMM6:    fw = 6;
         IMM8:    fw = 8;
         default: fw = 5;
      endcase
      field    = EXT_W'(immSrc) & ((EXT_W'(1) << fw) - EXT_W'(1));
      combined = (EXT_W'(acc) << fw) | field;
      w        = int'(cnt) * PREFIX_PAYLOAD_W + fw;
      lowMask  = (EXT_W'(1) << w) - EXT_W'(1);
      topMask  = EXT_W'(1) << (w - 1);
      // Fill above the chain's top bit; when the chain is wider than
      // DATA_WIDTH the fill lands above the kept bits, i.e. truncation.
      ext      = (|(combined & topMask)) ? (combined | ~lowMask) : combined;
      base     = ext[DATA_WIDTH-1:0];
      imm      = base;
      if (isShift(op)) begin
         imm = {base[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/imm_prefix_stage.sv
// Decode-stage immediate generator with chained 12-bit prefix instructions.
// Ports: i_valid/o_ready in, o_valid/i_ready out handshake; o_instr, o_imm, o_prefixed, o_err.
module imm_prefix_stage
   import imm_pkg::*;
#(
   parameter int         DATA_WIDTH    = 16,
   parameter int         MAX_PREFIX    = 2,
   parameter logic [3:0] PREFIX_OPCODE = DEF_PREFIX_OPCODE
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [15:0]           i_instr,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [15:0]           o_instr,
   output logic [DATA_WIDTH-1:0] o_imm,
   output logic                  o_prefixed,
   output logic                  o_err
);

   localparam int ACC_W = MAX_PREFIX * PREFIX_PAYLOAD_W;
   localparam int CNT_W = $clog2(MAX_PREFIX + 1);

   pfxState_e             state, stateNext;
   logic [ACC_W-1:0]      acc, accNext;
   logic [CNT_W-1:0]      cnt, cntNext;
   logic                  validNext;
   logic [15:0]           instrNext;
   logic [DATA_WIDTH-1:0] immNext;
   logic                  prefixedNext;
   logic                  errNext;
   logic [DATA_WIDTH-1:0] immComb;
   logic                  accept;
   logic                  isPrefix;

   assign o_ready  = ~o_valid | i_ready;
   assign accept   = i_valid & o_ready;
   assign isPrefix = i_instr[15:12] == PREFIX_OPCODE;

   imm_extract #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_PREFIX (MAX_PREFIX),
      .CNT_W      (CNT_W)
   ) uExtract (
      .op     (i_instr[15:12]),
      .immSrc (i_instr[7:0]),
      .acc    (acc),
      .cnt    (cnt),
      .imm    (immComb)
   );

   always_comb begin
      stateNext    = state;
      accNext      = acc;
      cntNext      = cnt;
      validNext    = o_valid;
      instrNext    = o_instr;
      immNext      = o_imm;
      prefixedNext = o_prefixed;
      errNext      = 1'b0;
      if (i_flush) begin
         stateNext = IDLE;
         accNext   = '0;
         cntNext   = '0;
         validNext = 1'b0;
      end else begin
         if (o_valid & i_ready) begin
            validNext = 1'b0;
         end
         if (accept) begin
            if (isPrefix) begin
               if (cnt == CNT_W'(MAX_PREFIX)) begin
                  errNext = 1'b1;
               end else begin
                  accNext   = ACC_W'({acc, i_instr[11:0]});
                  cntNext   = cnt + CNT_W'(1);
                  stateNext = PREFIXED;
               end
            end else begin
               validNext    = 1'b1;
               instrNext    = i_instr;
               immNext      = immComb;
               prefixedNext = state == PREFIXED;
               accNext      = '0;
               cntNext      = '0;
               stateNext    = IDLE;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         o_valid    <= 1'b0;
         o_instr    <= '0;
         o_imm      <= '0;
         o_prefixed <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         state      <= stateNext;
         acc        <= accNext;
         cnt        <= cntNext;
         o_valid    <= validNext;
         o_instr    <= instrNext;
         o_imm      <= immNext;
         o_prefixed <= prefixedNext;
         o_err      <= errNext;
      end
   end

endmodule

// File: tb/tb_imm_prefix_stage.sv
// Self-checking bench for imm_prefix_stage: directed steps then random traffic.
// Reference model works on a queue of prefix payloads and plain integer arithmetic.
module tb_imm_prefix_stage;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_flush;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_instr;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_instr;
   logic [15:0] o_imm;
   logic        o_prefixed;
   logic        o_err;

   int total = 0;
   int bad   = 0;

   bit          mValid = 1'b0;
   bit          mPre   = 1'b0;
   bit          mErr   = 1'b0;
   logic [15:0] mInstr = '0;
   logic [15:0] mImm   = '0;
   int          q[$];

   imm_prefix_stage dut (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_flush    (i_flush),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_instr    (i_instr),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_instr    (o_instr),
      .o_imm      (o_imm),
      .o_prefixed (o_prefixed),
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] refImm(input logic [15:0] ins);
      int     op;
      int     fw;
      int     w;
      longint v;
      op = int'(ins[15:12]);
      if (op == 0 || op == 1 || op == 4 || op == 5) fw = 6;
      else if (op == 2 || op == 10) fw = 8;
      else fw = 5;
      v = 0;
      foreach (q[i]) v = v * 4096 + longint'(q[i]);
      v = v * (longint'(1) << fw) + longint'(int'(ins[7:0]) & ((1 << fw) - 1));
      w = 12 * q.size() + fw;
      if (w < 16 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      if (op < 8) v = v * 2;
      return v[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [15:0] ins, input bit rdy,
                       input bit fl, input bit rst);
      bit acc;
      i_valid = v;
      i_instr = ins;
      i_ready = rdy;
      i_flush = fl;
      i_rstn  = ~rst;
      #1;
      chk("o_ready", 32'(o_ready), 32'(!mValid | rdy));
      @(posedge i_clk);
      if (rst) begin
         mValid = 0; mInstr = '0; mImm = '0; mPre = 0; mErr = 0;
         q.delete();
      end else if (fl) begin
         mValid = 0; mErr = 0;
         q.delete();
      end else begin
         acc  = v & (!mValid | rdy);
         mErr = 0;
         if (mValid & rdy) mValid = 0;
         if (acc) begin
            if (ins[15:12] == 4'hF) begin
               if (q.size() == 2) mErr = 1;
               else q.push_back(int'(ins[11:0]));
            end else begin
               mImm   = refImm(ins);
               mInstr = ins;
               mPre   = q.size() > 0;
               mValid = 1;
               q.delete();
            end
         end
      end
      #1;
      chk("o_valid", 32'(o_valid), 32'(mValid));
      chk("o_err", 32'(o_err), 32'(mErr));
      chk("o_instr", 32'(o_instr), 32'(mInstr));
      chk("o_imm", 32'(o_imm), 32'(mImm));
      chk("o_prefixed", 32'(o_prefixed), 32'(mPre));
   endtask

   initial begin
      logic [15:0] held;
      logic [15:0] rin;
      i_rstn  = 1'b0;
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_instr = '0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset valid", 32'(o_valid), 32'h0);
      chk("reset imm", 32'(o_imm), 32'h0);
      chk("reset err", 32'(o_err), 32'h0);

      step(1, 16'h2080, 1, 0, 0);
      chk("imm8 shl", 32'(o_imm), 32'hFF00);
      chk("imm8 valid", 32'(o_valid), 32'h1);
      chk("imm8 pre", 32'(o_prefixed), 32'h0);
      step(1, 16'h9010, 1, 0, 0);
      chk("imm5", 32'(o_imm), 32'hFFF0);
      step(1, 16'h401F, 1, 0, 0);
      chk("imm6 shl", 32'(o_imm), 32'h003E);
      chk("b2b valid", 32'(o_valid), 32'h1);

      step(1, 16'hF123, 1, 0, 0);
      chk("prefix no out", 32'(o_valid), 32'h0);
      step(1, 16'h9005, 1, 0, 0);
      chk("chain imm", 32'(o_imm), 32'h2465);
      chk("chain pre", 32'(o_prefixed), 32'h1);
      step(1, 16'h9005, 1, 0, 0);
      chk("after chain imm", 32'(o_imm), 32'h0005);
      chk("after chain pre", 32'(o_prefixed), 32'h0);

      held = o_imm;
      for (int i = 0; i < 3; i++) begin
         step(1, 16'h9001, 0, 0, 0);
         chk("bp ready", 32'(o_ready), 32'h0);
         chk("bp hold", 32'(o_imm), 32'(held));
      end
      step(1, 16'h9001, 1, 0, 0);
      chk("bp release", 32'(o_imm), 32'h0001);

      step(1, 16'hF001, 1, 0, 0);
      step(1, 16'hF002, 1, 0, 0);
      chk("no err yet", 32'(o_err), 32'h0);
      step(1, 16'hF003, 1, 0, 0);
      chk("ovf err", 32'(o_err), 32'h1);
      step(0, 16'h0000, 1, 0, 0);
      chk("err pulse", 32'(o_err), 32'h0);
      step(1, 16'h9000, 1, 0, 0);
      chk("ovf imm", 32'(o_imm), 32'h0040);

      step(1, 16'hF7FF, 1, 0, 0);
      step(1, 16'h9005, 1, 1, 0);
      chk("flush no out", 32'(o_valid), 32'h0);
      step(1, 16'h9005, 1, 0, 0);
      chk("post flush", 32'(o_imm), 32'h0005);

      step(1, 16'hF7FF, 1, 0, 0);
      step(1, 16'h9005, 1, 0, 1);
      chk("rst valid", 32'(o_valid), 32'h0);
      chk("rst imm", 32'(o_imm), 32'h0);
      chk("rst instr", 32'(o_instr), 32'h0);
      step(1, 16'h9005, 1, 0, 0);
      chk("post rst", 32'(o_imm), 32'h0005);

      for (int i = 0; i < 500; i++) begin
         rin = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rin[15:12] = 4'hF;
         step(bit'($urandom_range(0, 3) != 0), rin,
              bit'($urandom_range(0, 3) != 0),
              bit'($urandom_range(0, 29) == 0),
              bit'($urandom_range(0, 79) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
